serial_full_subtractor: RTL and testbench

SERIAL_FULL_SUBTRACTOR -- requirements
Module: serial_full_subtractor

---
 rtl/serial_full_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_full_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial full subtractor, LSB first, valid/ready operand and result handshakes
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             bit_valid,
    output logic             diff_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic [IW-1:0]    idx_q;

    logic a_bit;
    logic b_bit;
    logic d;
    logic br_nxt;

    // One full-subtractor slice, fed from the operand bit selected by idx_q
    assign a_bit  = a_q[idx_q];
    assign b_bit  = b_q[idx_q];
    assign d      = a_bit ^ b_bit ^ br_q;
    assign br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    assign difference = diff_q;
    assign borrow_out = br_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        diff_bit  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bit_valid = 1'b1;
                diff_bit  = d;
                if (idx_q == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Release goes to IDLE only; the next accept needs a fresh IDLE cycle
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            idx_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= minuend;
                        b_q    <= subtrahend;
                        br_q   <= borrow_in;
                        diff_q <= '0;
                        idx_q  <= '0;
                    end
                end
                RUN: begin
                    diff_q[idx_q] <= d;
                    br_q          <= br_nxt;
                    idx_q         <= idx_q + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb/tb_serial_full_subtractor.sv - directed and reference-model checks of serial_full_subtractor at WIDTH 2, 8 and 32
module tb_serial_full_subtractor;

    logic        clk;
    logic        rs  [3];
    logic        iv  [3];
    logic        orr [3];
    logic        bi  [3];
    logic [31:0] ma  [3];
    logic [31:0] sb  [3];

    wire         ir  [3];
    wire         bv  [3];
    wire         db  [3];
    wire         ov  [3];
    wire         bo  [3];
    wire  [31:0] df  [3];
    wire  [1:0]  df2;
    wire  [7:0]  df8;
    wire  [31:0] df32;

    int n_vec = 0;
    int n_err = 0;

    assign df[0] = {30'b0, df2};
    assign df[1] = {24'b0, df8};
    assign df[2] = df32;

    serial_full_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rs[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .minuend(ma[0][1:0]), .subtrahend(sb[0][1:0]), .borrow_in(bi[0]),
        .bit_valid(bv[0]), .diff_bit(db[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .difference(df2), .borrow_out(bo[0])
    );

    serial_full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rs[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .minuend(ma[1][7:0]), .subtrahend(sb[1][7:0]), .borrow_in(bi[1]),
        .bit_valid(bv[1]), .diff_bit(db[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .difference(df8), .borrow_out(bo[1])
    );

    serial_full_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rs[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .minuend(ma[2]), .subtrahend(sb[2]), .borrow_in(bi[2]),
        .bit_valid(bv[2]), .diff_bit(db[2]), .out_valid(ov[2]), .out_ready(orr[2]),
        .difference(df32), .borrow_out(bo[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge, in DONE (rel=0) or back in IDLE (rel=1)
    task automatic run_op(input int k, input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] exp_d, input logic exp_b, input logic rel);
        int bound;
        iv[k] = 1'b1;
        ma[k] = a;
        sb[k] = b;
        bi[k] = bin;
        bound = 0;
        while (!ir[k] && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        check("accept_ready", 64'(ir[k]), 64'd1);
        @(negedge clk);
        iv[k] = 1'b0;
        ma[k] = $urandom;
        sb[k] = $urandom;
        bi[k] = 1'($urandom);
        for (int i = 0; i < w; i++) begin
            check("run_bit_valid", 64'(bv[k]), 64'd1);
            check("run_diff_bit", 64'(db[k]), 64'(exp_d[i]));
            check("run_out_valid", 64'(ov[k]), 64'd0);
            @(negedge clk);
        end
        check("done_out_valid", 64'(ov[k]), 64'd1);
        check("done_bit_valid", 64'(bv[k]), 64'd0);
        check("done_difference", 64'(df[k]), 64'(exp_d));
        check("done_borrow_out", 64'(bo[k]), 64'(exp_b));
        if (rel) begin
            orr[k] = 1'b1;
            @(negedge clk);
            orr[k] = 1'b0;
            check("release_out_valid", 64'(ov[k]), 64'd0);
            check("release_in_ready", 64'(ir[k]), 64'd1);
        end
    endtask

    task automatic rand_ops(input int k, input int w, input int n);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] full;
        logic        bin;
        mask = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int j = 0; j < n; j++) begin
            a    = 64'($urandom) & mask;
            b    = 64'($urandom) & mask;
            bin  = 1'($urandom);
            if (j % 7 == 0) a = b;
            full = a - b - 64'(bin);
            run_op(k, w, a[31:0], b[31:0], bin, full[31:0] & mask[31:0], a < (b + 64'(bin)), 1'b1);
        end
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check({tag, "_in_ready"}, 64'(ir[k]), 64'd1);
        check({tag, "_out_valid"}, 64'(ov[k]), 64'd0);
        check({tag, "_bit_valid"}, 64'(bv[k]), 64'd0);
        check({tag, "_diff_bit"}, 64'(db[k]), 64'd0);
        check({tag, "_difference"}, 64'(df[k]), 64'd0);
        check({tag, "_borrow_out"}, 64'(bo[k]), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rs[k]  = 1'b1;
            iv[k]  = 1'b0;
            orr[k] = 1'b0;
            bi[k]  = 1'b0;
            ma[k]  = '0;
            sb[k]  = '0;
        end
        iv[1] = 1'b1;
        ma[1] = 32'd9;
        sb[1] = 32'd4;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rs[k] = 1'b0;
        for (int k = 0; k < 3; k++) check_reset_vals(k, "reset");
        iv[1] = 1'b0;
        @(negedge clk);
        check("idle_hold_bit_valid", 64'(bv[1]), 64'd0);
        check("idle_hold_in_ready", 64'(ir[1]), 64'd1);

        run_op(1, 8, 32'd5,   32'd3,   1'b0, 32'h02, 1'b0, 1'b1);
        run_op(1, 8, 32'd3,   32'd5,   1'b0, 32'hFE, 1'b1, 1'b1);
        run_op(1, 8, 32'd0,   32'd0,   1'b1, 32'hFF, 1'b1, 1'b1);
        run_op(1, 8, 32'd255, 32'd255, 1'b0, 32'h00, 1'b0, 1'b1);
        run_op(1, 8, 32'd0,   32'd255, 1'b1, 32'h00, 1'b1, 1'b1);
        run_op(1, 8, 32'd128, 32'd1,   1'b1, 32'h7E, 1'b0, 1'b1);

        // Result held in DONE while new operands and a stray release are offered
        orr[1] = 1'b1;
        run_op(1, 8, 32'd100, 32'd37, 1'b0, 32'd63, 1'b0, 1'b0);
        orr[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iv[1] = 1'b1;
            ma[1] = 32'd17 * i;
            sb[1] = 32'd3;
            check("hold_out_valid", 64'(ov[1]), 64'd1);
            check("hold_in_ready", 64'(ir[1]), 64'd0);
            check("hold_difference", 64'(df[1]), 64'd63);
            check("hold_borrow_out", 64'(bo[1]), 64'd0);
            @(negedge clk);
        end
        ma[1] = 32'd15;
        sb[1] = 32'd1;
        orr[1] = 1'b1;
        @(negedge clk);
        orr[1] = 1'b0;
        check("release_no_accept_bit_valid", 64'(bv[1]), 64'd0);
        check("release_idle_in_ready", 64'(ir[1]), 64'd1);
        check("release_idle_out_valid", 64'(ov[1]), 64'd0);
        run_op(1, 8, 32'd15, 32'd1, 1'b0, 32'd14, 1'b0, 1'b1);

        // Reset while bit 3 is on the output
        iv[1] = 1'b1;
        ma[1] = 32'd170;
        sb[1] = 32'd85;
        bi[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("midrun_bit_valid", 64'(bv[1]), 64'd1);
        rs[1] = 1'b1;
        @(negedge clk);
        rs[1] = 1'b0;
        check_reset_vals(1, "midrun_reset");
        run_op(1, 8, 32'd200, 32'd100, 1'b0, 32'd100, 1'b0, 1'b1);

        fork
            rand_ops(0, 2, 1000);
            rand_ops(1, 8, 1000);
            rand_ops(2, 32, 1000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
